video_pattern_gen: RTL and testbench

Parametrised multi-mode test-pattern source for the HDMI/LCD output path. It sits between the video timing driver, which supplies pixel coordinates and data-enable, and the RGB888 encoder. It generates four patterns selectable at frame boundaries:
- N-bar colour bars
- checkerboard
- horizontal grey ramp
- bouncing box

Output is a 2-stage registered pipeline with an aligned valid flag.

---
 rtl/video_pattern_gen.sv | 107 ++++++++++
 tb/tb_video_pattern_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: four-mode test-pattern source (bars, checker, grey ramp, bouncing box) with a 2-stage registered output
// ports: pixel_clk clock; sys_rst async active-high reset; pixel_xpos/pixel_ypos/pixel_de timing-driver coordinates and enable;
//        mode_sel requested pattern (latched at frame start); pixel_data RGB888 {R,G,B}; data_valid pixel_de delayed 2 cycles
module video_pattern_gen #(
   parameter int H_DISP     = 1920,
   parameter int V_DISP     = 1080,
   parameter int COORD_W    = 11,
   parameter int NUM_BARS   = 8,
   parameter int CHECK_LOG2 = 6,
   parameter int BOX_SIZE   = 64,
   parameter int BOX_STEP   = 2
) (
   input  logic               pixel_clk,
   input  logic               sys_rst,
   input  logic [COORD_W-1:0] pixel_xpos,
   input  logic [COORD_W-1:0] pixel_ypos,
   input  logic               pixel_de,
   input  logic [1:0]         mode_sel,
   output logic [23:0]        pixel_data,
   output logic               data_valid
);
   localparam int BAR_W  = H_DISP / NUM_BARS;
   localparam int RAMP_K = (256 << 16) / H_DISP;
   localparam int PW     = COORD_W + 20;
   localparam logic [23:0] BAR_RGB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
   localparam logic [COORD_W-1:0] BOX_W = COORD_W'(BOX_SIZE);
   localparam logic [COORD_W-1:0] LIM_X = COORD_W'(H_DISP - BOX_SIZE);
   localparam logic [COORD_W-1:0] LIM_Y = COORD_W'(V_DISP - BOX_SIZE);
   localparam logic [COORD_W:0]   STEP  = (COORD_W + 1)'(BOX_STEP);

   logic [1:0]         active_mode, cur_mode, s1_mode;
   logic [COORD_W-1:0] bar_cnt, cur_cnt, box_x, box_y;
   logic [2:0]         bar_idx, cur_idx, s1_bar;
   logic               dir_x, dir_y, s1_de, s1_chk, s1_hit, hit;
   logic               line_start, frame_start, frame_end, bar_wrap;
   logic [PW-1:0]      ramp_prod;
   logic [COORD_W+3:0] ramp_shift;
   logic [7:0]         ramp_g, s1_g;
   logic [COORD_W:0]   nx, ny;

   // returns {dir, pos}; dir=0 means moving towards the limit
   function automatic logic [COORD_W:0] bounce(input logic [COORD_W-1:0] pos, input logic dir,
                                               input logic [COORD_W-1:0] lim);
      return !dir ? (({1'b0, pos} + STEP >= {1'b0, lim}) ? {1'b1, lim} : {1'b0, pos + STEP[COORD_W-1:0]})
                  : (({1'b0, pos} <= STEP) ? '0 : {1'b1, pos - STEP[COORD_W-1:0]});
   endfunction

   always_comb begin
      line_start  = pixel_de && pixel_xpos == '0;
      frame_start = line_start && pixel_ypos == '0;
      frame_end   = pixel_de && pixel_xpos == COORD_W'(H_DISP - 1) && pixel_ypos == COORD_W'(V_DISP - 1);
      cur_mode    = frame_start ? mode_sel : active_mode;
      // the line's first pixel restarts the bar walk without waiting for the registered counter
      cur_cnt     = line_start ? '0 : bar_cnt;
      cur_idx     = line_start ? '0 : bar_idx;
      bar_wrap    = cur_cnt == COORD_W'(BAR_W - 1);
      ramp_prod   = PW'(pixel_xpos) * PW'(RAMP_K);
      ramp_shift  = ramp_prod[PW-1:16];
      ramp_g      = ramp_shift > (COORD_W + 4)'(255) ? 8'hFF : ramp_shift[7:0];
      hit         = pixel_xpos >= box_x && pixel_xpos < box_x + BOX_W &&
                    pixel_ypos >= box_y && pixel_ypos < box_y + BOX_W;
      nx          = bounce(box_x, dir_x, LIM_X);
      ny          = bounce(box_y, dir_y, LIM_Y);
   end

   always_ff @(posedge pixel_clk or posedge sys_rst) begin
      if (sys_rst) begin
         active_mode <= '0;
         bar_cnt     <= '0;
         bar_idx     <= '0;
         box_x       <= '0;
         box_y       <= '0;
         dir_x       <= 1'b0;
         dir_y       <= 1'b0;
         s1_de       <= 1'b0;
         s1_mode     <= '0;
         s1_bar      <= '0;
         s1_chk      <= 1'b0;
         s1_g        <= '0;
         s1_hit      <= 1'b0;
         pixel_data  <= '0;
         data_valid  <= 1'b0;
      end else begin
         active_mode <= cur_mode;
         if (pixel_de) begin
            bar_cnt <= bar_wrap ? '0 : cur_cnt + 1'b1;
            bar_idx <= (bar_wrap && cur_idx != 3'(NUM_BARS - 1)) ? cur_idx + 3'd1 : cur_idx;
         end
         if (frame_end) begin
            {dir_x, box_x} <= nx;
            {dir_y, box_y} <= ny;
         end
         s1_de      <= pixel_de;
         s1_mode    <= cur_mode;
         s1_bar     <= cur_idx;
         s1_chk     <= pixel_xpos[CHECK_LOG2] ^ pixel_ypos[CHECK_LOG2];
         s1_g       <= ramp_g;
         s1_hit     <= hit;
         data_valid <= s1_de;
         pixel_data <= !s1_de          ? 24'h000000 :
                       s1_mode == 2'd0 ? BAR_RGB[s1_bar] :
                       s1_mode == 2'd1 ? {24{s1_chk}} :
                       s1_mode == 2'd2 ? {s1_g, s1_g, s1_g} : {24{s1_hit}};
      end
   end
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: checks two pattern generators (8 and 5 bars) against an arithmetic model every cycle
// ports: none (top-level bench)
module tb_video_pattern_gen;
   localparam int H = 64, V = 8, CW = 7, CL = 2, BS = 4, BST = 2;
   localparam logic [23:0] PAL [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
   logic          pixel_clk = 1'b0, sys_rst = 1'b1, pixel_de = 1'b0;
   logic [CW-1:0] pixel_xpos = '0, pixel_ypos = '0;
   logic [1:0]    mode_sel = '0;
   logic [23:0]   data_a, data_b;
   logic          dv_a, dv_b;
   logic [24:0]   e1a = '0, e2a = '0, e1b = '0, e2b = '0;
   logic [1:0]    mmode = '0, cm;
   int            nfr = 0;
   int            checks = 0, errors = 0;
   logic          fs, fe;

   always #5 pixel_clk = ~pixel_clk;

   video_pattern_gen #(.H_DISP(H), .V_DISP(V), .COORD_W(CW), .NUM_BARS(8), .CHECK_LOG2(CL),
                       .BOX_SIZE(BS), .BOX_STEP(BST)) dut_a (
      .pixel_clk(pixel_clk), .sys_rst(sys_rst), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
      .pixel_de(pixel_de), .mode_sel(mode_sel), .pixel_data(data_a), .data_valid(dv_a));

   video_pattern_gen #(.H_DISP(H), .V_DISP(V), .COORD_W(CW), .NUM_BARS(5), .CHECK_LOG2(CL),
                       .BOX_SIZE(BS), .BOX_STEP(BST)) dut_b (
      .pixel_clk(pixel_clk), .sys_rst(sys_rst), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
      .pixel_de(pixel_de), .mode_sel(mode_sel), .pixel_data(data_b), .data_valid(dv_b));

   // box position after n frame updates is a triangle wave between 0 and lim
   function automatic int tri_pos(int n, int lim);
      int p;
      p = (BST * n) % (2 * lim);
      return p <= lim ? p : 2 * lim - p;
   endfunction

   function automatic logic [23:0] exp_rgb(int m, int x, int y, int nb, int n);
      int idx, g, bx, by;
      idx = x / (H / nb);
      idx = idx < nb - 1 ? idx : nb - 1;
      g   = (x * ((256 << 16) / H)) >> 16;
      g   = g > 255 ? 255 : g;
      bx  = tri_pos(n, H - BS);
      by  = tri_pos(n, V - BS);
      case (m)
         0:       return PAL[3'(idx)];
         1:       return (((x >> CL) ^ (y >> CL)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
         2:       return {3{8'(g)}};
         default: return (x >= bx && x < bx + BS && y >= by && y < by + BS) ? 24'hFFFFFF : 24'h000000;
      endcase
   endfunction

   assign fs = pixel_de && pixel_xpos == '0 && pixel_ypos == '0;
   assign fe = pixel_de && int'(pixel_xpos) == H - 1 && int'(pixel_ypos) == V - 1;
   assign cm = fs ? mode_sel : mmode;

   always @(posedge pixel_clk or posedge sys_rst) begin
      if (sys_rst) begin
         e1a <= '0; e2a <= '0; e1b <= '0; e2b <= '0; mmode <= '0; nfr <= 0;
      end else begin
         e2a   <= e1a;
         e2b   <= e1b;
         e1a   <= pixel_de ? {1'b1, exp_rgb(int'(cm), int'(pixel_xpos), int'(pixel_ypos), 8, nfr)} : '0;
         e1b   <= pixel_de ? {1'b1, exp_rgb(int'(cm), int'(pixel_xpos), int'(pixel_ypos), 5, nfr)} : '0;
         mmode <= cm;
         nfr   <= fe ? nfr + 1 : nfr;
      end
   end

   task automatic cmp(string nm, logic [23:0] got, logic [23:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic pix(int x, int y, logic de);
      pixel_xpos = CW'(x);
      pixel_ypos = CW'(y);
      pixel_de   = de;
      @(posedge pixel_clk);
      @(negedge pixel_clk);
      cmp("a_valid", 24'(dv_a), 24'(e2a[24]));
      cmp("a_data", data_a, e2a[23:0]);
      cmp("b_valid", 24'(dv_b), 24'(e2b[24]));
      cmp("b_data", data_b, e2b[23:0]);
   endtask

   task automatic line(int y, int x0);
      for (int x = x0; x < H; x++) pix(x, y, 1'b1);
      pix(H, y, 1'b0);
      pix(H, y, 1'b0);
   endtask

   task automatic frame();
      for (int y = 0; y < V; y++) line(y, 0);
   endtask

   initial begin
      repeat (3) pix(0, 0, 1'b0);
      cmp("rst_data", data_a, 24'h0);
      cmp("rst_valid", 24'(dv_a), 24'h0);
      #1 sys_rst = 1'b0;
      pix(5, 3, 1'b0);
      // first pixel appears two cycles after it is presented
      pix(0, 0, 1'b1);
      cmp("lat_wait", 24'(dv_a), 24'h0);
      pix(1, 0, 1'b1);
      cmp("lat_valid", 24'(dv_a), 24'h1);
      cmp("lat_first", data_a, 24'hFFFFFF);
      line(0, 2);
      for (int y = 1; y < V; y++) line(y, 0);
      // hand-computed pins on the model
      cmp("m_bar_x0", exp_rgb(0, 0, 0, 8, 0), 24'hFFFFFF);
      cmp("m_bar_x8", exp_rgb(0, 8, 0, 8, 0), 24'hFFFF00);
      cmp("m_bar_x63", exp_rgb(0, 63, 0, 8, 0), 24'h000000);
      cmp("m_bar5_x47", exp_rgb(0, 47, 0, 5, 0), 24'h00FF00);
      cmp("m_bar5_x60", exp_rgb(0, 60, 0, 5, 0), 24'hFF00FF);
      cmp("m_chk_3_0", exp_rgb(1, 3, 0, 8, 0), 24'h000000);
      cmp("m_chk_4_0", exp_rgb(1, 4, 0, 8, 0), 24'hFFFFFF);
      cmp("m_chk_4_4", exp_rgb(1, 4, 4, 8, 0), 24'h000000);
      cmp("m_ramp_0", exp_rgb(2, 0, 3, 8, 0), 24'h000000);
      cmp("m_ramp_10", exp_rgb(2, 10, 3, 8, 0), 24'h282828);
      cmp("m_ramp_63", exp_rgb(2, 63, 3, 8, 0), 24'hFCFCFC);
      cmp("m_bx_30", 24'(tri_pos(30, H - BS)), 24'd60);
      cmp("m_bx_31", 24'(tri_pos(31, H - BS)), 24'd58);
      cmp("m_by_2", 24'(tri_pos(2, V - BS)), 24'd4);
      cmp("m_by_4", 24'(tri_pos(4, V - BS)), 24'd0);
      // mid-frame mode request is held off until the next frame start
      for (int y = 0; y < 4; y++) line(y, 0);
      mode_sel = 2'd2;
      for (int y = 4; y < V; y++) line(y, 0);
      cmp("latch_hold", 24'(mmode), 24'd0);
      frame();
      cmp("latch_new", 24'(mmode), 24'd2);
      mode_sel = 2'd1;
      frame();
      // de dropout mid-line with xpos held
      mode_sel = 2'd0;
      for (int x = 0; x < 20; x++) pix(x, 0, 1'b1);
      pix(20, 0, 1'b0);
      cmp("blank_pre", 24'(dv_a), 24'h1);
      pix(20, 0, 1'b0);
      cmp("blank_1", {dv_a, data_a[22:0]}, 24'h0);
      pix(20, 0, 1'b0);
      cmp("blank_2", {dv_a, data_a[22:0]}, 24'h0);
      pix(20, 0, 1'b1);
      cmp("blank_3", {dv_a, data_a[22:0]}, 24'h0);
      pix(21, 0, 1'b1);
      cmp("blank_post", 24'(dv_a), 24'h1);
      line(0, 22);
      for (int y = 1; y < V; y++) line(y, 0);
      // asynchronous reset mid-line
      mode_sel = 2'd1;
      for (int x = 0; x < 30; x++) pix(x, 0, 1'b1);
      #1 sys_rst = 1'b1;
      #1;
      cmp("arst_data", data_a, 24'h0);
      cmp("arst_valid", 24'(dv_a), 24'h0);
      pix(30, 0, 1'b0);
      pix(30, 0, 1'b0);
      #1 sys_rst = 1'b0;
      for (int i = 0; i < 4; i++) pix(H, 0, 1'b0);
      for (int y = 1; y < V; y++) line(y, 0);
      cmp("arst_mode", 24'(mmode), 24'd0);
      frame();
      cmp("arst_relatch", 24'(mmode), 24'd1);
      // bouncing box from a fresh reset
      #1 sys_rst = 1'b1;
      pix(H, 0, 1'b0);
      #1 sys_rst = 1'b0;
      pix(H, 0, 1'b0);
      mode_sel = 2'd3;
      for (int f = 0; f < 40; f++) begin
         cmp("box_frames", 24'(nfr), 24'(f));
         if (f == 2) cmp("box_y_limit", 24'(tri_pos(nfr, V - BS)), 24'd4);
         if (f == 30) cmp("box_x_limit", 24'(tri_pos(nfr, H - BS)), 24'd60);
         if (f == 31) cmp("box_x_back", 24'(tri_pos(nfr, H - BS)), 24'd58);
         frame();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
